// File: rtl/serial_sub.sv
// serial_sub: bit-serial subtractor computing a - b - bin, LSB first, one bit
// per clock through a single full-subtractor cell and a registered borrow.
//
// Optional feature macro: SERIAL_SUB_OVF_EN adds the ovf output (signed
// two's-complement overflow of a - b - bin).
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands valid
//   in_ready   block can accept operands (IDLE)
//   a, b       minuend / subtrahend, unsigned, WIDTH bits
//   bin        borrow in
//   out_valid  result valid (DONE)
//   out_ready  consumer accepts result
//   diff       (a - b - bin) mod 2^WIDTH
//   bout       borrow out, 1 iff a < b + bin
//   busy       high in RUN or DONE
//   ovf        signed overflow (only with SERIAL_SUB_OVF_EN)
module serial_sub #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic            borrow;
    logic [CW-1:0]   cnt;

    logic            ai;
    logic            bi;
    logic            d;
    logic            borrow_nxt;
    logic            last;

    // Single full-subtractor cell on the current LSBs
    always_comb begin
        ai         = a_sh[0];
        bi         = b_sh[0];
        d          = ai ^ bi ^ borrow;
        borrow_nxt = (~ai & bi) | (~(ai ^ bi) & borrow);
        last       = (cnt == CW'(WIDTH - 1));
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Handshake flags decode directly from the state register
    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);

    // State register and serial datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            bout   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        borrow <= bin;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    borrow <= borrow_nxt;
                    diff   <= {d, diff[WIDTH-1:1]};
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        bout <= borrow_nxt;
`ifdef SERIAL_SUB_OVF_EN
                        // Borrow into MSB xor borrow out of MSB
                        ovf  <= borrow ^ borrow_nxt;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: directed and random checks of serial_sub (WIDTH=8) using a
// scoreboard of expected results pushed at input accept, popped at output
// handshake.
module tb_serial_sub;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
    logic         busy;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    serial_sub #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .busy      (busy)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_out = 0;

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        exp_t       e;
        logic [W:0] full;
        int         r;
        full = {1'b0, x} - {1'b0, y} - (W+1)'(c);
        r    = int'($signed(x)) - int'($signed(y)) - int'(c);
        e.d  = full[W-1:0];
        e.bo = full[W];
        e.ov = (r < -128) || (r > 127);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Act on handshakes implied by the current inputs/outputs, then advance one clock
    task automatic step();
        exp_t e;
        if (in_valid && in_ready) exp_q.push_back(model(a, b, bin));
        if (out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
                check("sb_pending", 32'(exp_q.size()), 32'(1));
            end else begin
                e = exp_q.pop_front();
                check("diff", 32'(diff), 32'(e.d));
                check("bout", 32'(bout), 32'(e.bo));
`ifdef SERIAL_SUB_OVF_EN
                check("ovf", 32'(ovf), 32'(e.ov));
`endif
            end
        end
        @(negedge clk);
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
        check("out_valid_timeout", 32'(out_valid), 32'(1));
    endtask

    // One full transaction with immediate out_ready and a latency check
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int lat;
        a = x; b = y; bin = c; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        wait_out(lat);
        check("latency", 32'(lat), 32'(W));
        step();
        check("in_ready_after_hs", 32'(in_ready), 32'(1));
    endtask

    logic [W-1:0] ta [100];
    logic [W-1:0] tb [100];
    logic         tc [100];

    initial begin
        int lat;
        int idx;
        int cyc;
        int n0;
        logic seen;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; bin = 1'b0;

        // Reset state
        #12;
        check("rst_in_ready",  32'(in_ready),  32'(1));
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_busy",      32'(busy),      32'(0));
        check("rst_diff",      32'(diff),      32'(0));
        check("rst_bout",      32'(bout),      32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic transactions
        run_op(8'h5A, 8'h23, 1'b0);
        run_op(8'h00, 8'h01, 1'b0);
        run_op(8'h10, 8'h0F, 1'b1);

        // Backpressure with an ignored in_valid pulse
        a = 8'hFF; b = 8'hFF; bin = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        wait_out(lat);
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", 32'(out_valid), 32'(1));
            check("bp_diff",      32'(diff),      32'(8'hFF));
            check("bp_bout",      32'(bout),      32'(1));
            if (i == 2) begin
                a = 8'h01; b = 8'h00; bin = 1'b0; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            check("bp_in_ready", 32'(in_ready), 32'(0));
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("bp_in_ready_hold", 32'(in_ready), 32'(0));
        step();
        check("bp_in_ready_after", 32'(in_ready), 32'(1));
        check("bp_sb_empty", 32'(exp_q.size()), 32'(0));

        // Asynchronous reset in the 4th RUN cycle
        a = 8'h33; b = 8'h11; bin = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step(); step();
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'(0));
        check("arst_busy",      32'(busy),      32'(0));
        check("arst_diff",      32'(diff),      32'(0));
        check("arst_bout",      32'(bout),      32'(0));
        check("arst_in_ready",  32'(in_ready),  32'(1));
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            seen |= out_valid;
            step();
        end
        check("arst_no_out", 32'(seen), 32'(0));
        run_op(8'h80, 8'h7F, 1'b0);

        // Signed-overflow cases
        run_op(8'h80, 8'h01, 1'b0);
        run_op(8'h05, 8'h03, 1'b0);

        // Back-to-back random with random out_ready
        for (int i = 0; i < 100; i++) begin
            ta[i] = 8'($urandom);
            tb[i] = 8'($urandom);
            tc[i] = 1'($urandom);
        end
        idx = 0; cyc = 0; n0 = n_out;
        while ((n_out - n0) < 100 && cyc < 5000) begin
            if (idx < 100) begin
                a = ta[idx]; b = tb[idx]; bin = tc[idx]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            out_ready = 1'($urandom_range(0, 1));
            if (in_valid && in_ready) idx++;
            step();
            cyc++;
        end
        in_valid = 1'b0;
        check("rand_results", 32'(n_out - n0), 32'(100));
        check("rand_accepted", 32'(idx), 32'(100));
        check("rand_sb_empty", 32'(exp_q.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
